// File: rtl/riscv_wb_checker.sv
// riscv_wb_checker: in-order writeback scoreboard comparing core writebacks against a preloaded (rd, value) FIFO.
// Latency: compare result (mismatch/err_count/mm_*) and the DONE transition are registered one cycle after the accepted writeback.
// Backpressure: exp_ready drops while the FIFO is full and pushes then are dropped; WB_CHK_LATENCY_EN adds last_gap/max_gap outputs.
module riscv_wb_checker #(
    parameter int XLEN      = 32,
    parameter int REG_AW    = 5,
    parameter int DEPTH     = 16,
    parameter int TIMEOUT   = 64,
    parameter int IGNORE_X0 = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              exp_valid,
    output logic              exp_ready,
    input  logic [REG_AW-1:0] exp_a,
    input  logic [XLEN-1:0]   exp_d,
    input  logic              start,
    input  logic              wb_e,
    input  logic [REG_AW-1:0] wb_a,
    input  logic [XLEN-1:0]   wb_d,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic              mismatch,
    output logic [15:0]       err_count,
    output logic [15:0]       mm_idx,
    output logic [REG_AW-1:0] mm_exp_a,
    output logic [REG_AW-1:0] mm_act_a,
    output logic [XLEN-1:0]   mm_exp_d,
    output logic [XLEN-1:0]   mm_act_d
`ifdef WB_CHK_LATENCY_EN
    ,
    output logic [15:0]       last_gap,
    output logic [15:0]       max_gap
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic [REG_AW-1:0] a;
        logic [XLEN-1:0]   d;
    } entry_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    entry_t        mem [DEPTH];
    entry_t        head;
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [TW-1:0] tcnt;
    logic [15:0]   idx;
    logic [15:0]   err_inc;
    logic          full, empty, push, pop, accepted, last_pop, cmp_bad;

    // Extra pointer bit distinguishes full from empty when the low bits match.
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty     = (wr_ptr == rd_ptr);
    assign exp_ready = !full;
    assign push      = exp_valid && !full && !clear;
    assign accepted  = wb_e && !((IGNORE_X0 != 0) && (wb_a == '0));
    assign pop       = (state == RUN) && accepted && !empty && !clear;
    assign head      = mem[rd_ptr[AW-1:0]];
    assign cmp_bad   = (head.a != wb_a) || (head.d != wb_d);
    // A simultaneous push keeps the FIFO non-empty, so only a lone pop of the last entry ends the run.
    assign last_pop  = ((rd_ptr + 1'b1) == wr_ptr) && !push;
    assign err_inc   = (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;
    assign pass      = done && (err_count == 16'd0) && !timeout;

    // Expected-entry storage; emptiness is tracked purely by the pointers, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= '{a: exp_a, d: exp_d};
    end

    // FIFO pointers: push in any state, pop only on accepted writebacks in RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Check FSM with registered status, compare result and first-mismatch capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            mismatch  <= 1'b0;
            err_count <= '0;
            mm_idx    <= '0;
            mm_exp_a  <= '0;
            mm_act_a  <= '0;
            mm_exp_d  <= '0;
            mm_act_d  <= '0;
            idx       <= '0;
            tcnt      <= '0;
        end else if (clear) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            mismatch  <= 1'b0;
            err_count <= '0;
            mm_idx    <= '0;
            mm_exp_a  <= '0;
            mm_act_a  <= '0;
            mm_exp_d  <= '0;
            mm_act_d  <= '0;
            idx       <= '0;
            tcnt      <= '0;
        end else begin
            mismatch <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (empty) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                            tcnt  <= '0;
                            idx   <= '0;
                        end
                    end
                end
                RUN: begin
                    if (pop) begin
                        tcnt <= '0;
                        idx  <= idx + 16'd1;
                        if (cmp_bad) begin
                            mismatch  <= 1'b1;
                            err_count <= err_inc;
                            // Overruns only happen in DONE, so a zero count here means no earlier mismatch.
                            if (err_count == 16'd0) begin
                                mm_idx   <= idx;
                                mm_exp_a <= head.a;
                                mm_act_a <= wb_a;
                                mm_exp_d <= head.d;
                                mm_act_d <= wb_d;
                            end
                        end
                        if (last_pop) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                DONE: begin
                    if (accepted) err_count <= err_inc;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef WB_CHK_LATENCY_EN
    logic [15:0] gap_cnt, gap_nxt;
    assign gap_nxt = (gap_cnt == 16'hFFFF) ? gap_cnt : gap_cnt + 16'd1;

    // Cycles between accepted writebacks in RUN, first gap measured from the start cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gap_cnt  <= '0;
            last_gap <= '0;
            max_gap  <= '0;
        end else if (clear) begin
            gap_cnt  <= '0;
            last_gap <= '0;
            max_gap  <= '0;
        end else if (state == IDLE && start && !empty) begin
            gap_cnt <= '0;
        end else if (state == RUN) begin
            if (pop) begin
                last_gap <= gap_nxt;
                if (gap_nxt > max_gap) max_gap <= gap_nxt;
                gap_cnt <= '0;
            end else begin
                gap_cnt <= gap_nxt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_riscv_wb_checker.sv
// tb_riscv_wb_checker: directed bench for the writeback scoreboard (DEPTH=4, TIMEOUT=8).
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled 1 time unit after the next one.
// Backpressure: FIFO fill, drop on full and push/pop overlap are exercised directly.
module tb_riscv_wb_checker;
    localparam int XLEN = 32;
    localparam int RAW  = 5;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            clear = 1'b0;
    logic            exp_valid = 1'b0;
    logic            exp_ready;
    logic [RAW-1:0]  exp_a = '0;
    logic [XLEN-1:0] exp_d = '0;
    logic            start = 1'b0;
    logic            wb_e = 1'b0;
    logic [RAW-1:0]  wb_a = '0;
    logic [XLEN-1:0] wb_d = '0;
    logic            busy, done, pass, timeout, mismatch;
    logic [15:0]     err_count, mm_idx;
    logic [RAW-1:0]  mm_exp_a, mm_act_a;
    logic [XLEN-1:0] mm_exp_d, mm_act_d;
`ifdef WB_CHK_LATENCY_EN
    logic [15:0]     last_gap, max_gap;
`endif

    int checks = 0;
    int errors = 0;
    int mm_pulses = 0;
    int mm_base;

    riscv_wb_checker #(
        .XLEN(XLEN), .REG_AW(RAW), .DEPTH(4), .TIMEOUT(8), .IGNORE_X0(1)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_a(exp_a), .exp_d(exp_d),
        .start(start), .wb_e(wb_e), .wb_a(wb_a), .wb_d(wb_d),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout), .mismatch(mismatch),
        .err_count(err_count), .mm_idx(mm_idx),
        .mm_exp_a(mm_exp_a), .mm_act_a(mm_act_a), .mm_exp_d(mm_exp_d), .mm_act_d(mm_act_d)
`ifdef WB_CHK_LATENCY_EN
        , .last_gap(last_gap), .max_gap(max_gap)
`endif
    );

    always #5 clk = ~clk;

    // Count mismatch pulses, sampled mid-cycle.
    always @(negedge clk) if (mismatch === 1'b1) mm_pulses++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input logic [RAW-1:0] a, input logic [XLEN-1:0] d);
        exp_valid = 1'b1; exp_a = a; exp_d = d;
        tick();
        exp_valid = 1'b0;
    endtask

    task automatic wb(input logic [RAW-1:0] a, input logic [XLEN-1:0] d);
        wb_e = 1'b1; wb_a = a; wb_d = d;
        tick();
        wb_e = 1'b0;
    endtask

    task automatic wb_push(input logic [RAW-1:0] a, input logic [XLEN-1:0] d,
                           input logic [RAW-1:0] pa, input logic [XLEN-1:0] pd);
        wb_e = 1'b1; wb_a = a; wb_d = d;
        exp_valid = 1'b1; exp_a = pa; exp_d = pd;
        tick();
        wb_e = 1'b0; exp_valid = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_exp_ready", 32'(exp_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        chk("rst_mm_idx", 32'(mm_idx), 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // 1: three matching writebacks 4, 5, 6 cycles after start
        push(5'd1, 32'hDEADBEEF);
        push(5'd2, 32'h12345678);
        push(5'd3, 32'hFEDCBA98);
        mm_base = mm_pulses;
        go();
        chk("t1_busy", 32'(busy), 32'd1);
        idle(3);
        wb(5'd1, 32'hDEADBEEF);
        wb(5'd2, 32'h12345678);
        chk("t1_not_done_yet", 32'(done), 32'd0);
        wb(5'd3, 32'hFEDCBA98);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_pass", 32'(pass), 32'd1);
        chk("t1_err", 32'(err_count), 32'd0);
        tick();
        chk("t1_no_mismatch", 32'(mm_pulses - mm_base), 32'd0);
        chk("t1_busy_low", 32'(busy), 32'd0);

        // 2: third writeback carries wrong data
        do_clear();
        chk("t2_clear_done", 32'(done), 32'd0);
        push(5'd1, 32'hDEADBEEF);
        push(5'd2, 32'h12345678);
        push(5'd3, 32'hFEDCBA98);
        mm_base = mm_pulses;
        go();
        wb(5'd1, 32'hDEADBEEF);
        wb(5'd2, 32'h12345678);
        wb(5'd3, 32'hFEDCBA99);
        chk("t2_mismatch_pulse", 32'(mismatch), 32'd1);
        tick();
        chk("t2_mismatch_low", 32'(mismatch), 32'd0);
        chk("t2_pulse_count", 32'(mm_pulses - mm_base), 32'd1);
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_err", 32'(err_count), 32'd1);
        chk("t2_pass", 32'(pass), 32'd0);
        chk("t2_mm_idx", 32'(mm_idx), 32'd2);
        chk("t2_mm_exp_a", 32'(mm_exp_a), 32'd3);
        chk("t2_mm_act_a", 32'(mm_act_a), 32'd3);
        chk("t2_mm_exp_d", mm_exp_d, 32'hFEDCBA98);
        chk("t2_mm_act_d", mm_act_d, 32'hFEDCBA99);

        // 3: timeout exactly 8 cycles after start
        do_clear();
        push(5'd9, 32'h00000001);
        go();
        idle(7);
        chk("t3_done_early", 32'(done), 32'd0);
        chk("t3_timeout_early", 32'(timeout), 32'd0);
        tick();
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_timeout", 32'(timeout), 32'd1);
        chk("t3_pass", 32'(pass), 32'd0);

        // 4: x0 writeback ignored, then overrun in DONE
        do_clear();
        chk("t4_timeout_cleared", 32'(timeout), 32'd0);
        push(5'd5, 32'h00000042);
        go();
        mm_base = mm_pulses;
        wb(5'd0, 32'h00000000);
        chk("t4_x0_busy", 32'(busy), 32'd1);
        chk("t4_x0_err", 32'(err_count), 32'd0);
        wb(5'd5, 32'h00000042);
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_pass", 32'(pass), 32'd1);
        wb(5'd7, 32'h00000077);
        chk("t4_overrun_err", 32'(err_count), 32'd1);
        chk("t4_overrun_pass", 32'(pass), 32'd0);
        chk("t4_no_pulse", 32'(mm_pulses - mm_base), 32'd0);
        chk("t4_no_capture", 32'(mm_act_a), 32'd0);

        // 5: DEPTH+1 pushes, last dropped; then push/pop overlap in RUN
        do_clear();
        exp_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_a = RAW'(i + 1);
            exp_d = 32'hA0 + i;
            if (i == 4) chk("t5_full_ready", 32'(exp_ready), 32'd0);
            tick();
        end
        exp_valid = 1'b0;
        go();
        wb(5'd1, 32'h000000A0);
        chk("t5_ready_after_pop", 32'(exp_ready), 32'd1);
        wb_push(5'd2, 32'h000000A1, 5'd6, 32'h000000B6);
        chk("t5_count_const1", 32'(exp_ready), 32'd1);
        wb_push(5'd3, 32'h000000A2, 5'd7, 32'h000000B7);
        chk("t5_count_const2", 32'(exp_ready), 32'd1);
        wb(5'd4, 32'h000000A3);
        wb(5'd6, 32'h000000B6);
        chk("t5_still_busy", 32'(busy), 32'd1);
        wb(5'd7, 32'h000000B7);
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_err", 32'(err_count), 32'd0);
        chk("t5_pass", 32'(pass), 32'd1);

        // 6: async reset mid-RUN discards all status and entries
        do_clear();
        push(5'd1, 32'h00000011);
        push(5'd2, 32'h00000022);
        push(5'd3, 32'h00000033);
        go();
        wb(5'd1, 32'h00000099);
        chk("t6_err_before", 32'(err_count), 32'd1);
        chk("t6_busy_before", 32'(busy), 32'd1);
        #3;
        reset = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_done", 32'(done), 32'd0);
        chk("t6_rst_err", 32'(err_count), 32'd0);
        chk("t6_rst_mm_act_d", mm_act_d, 32'd0);
        chk("t6_rst_exp_ready", 32'(exp_ready), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        go();
        chk("t6_empty_done", 32'(done), 32'd1);
        chk("t6_empty_pass", 32'(pass), 32'd1);
        go();
        chk("t6_start_ignored", 32'(done), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
